// File: rtl/nes_bus_pkg.sv
// Shared definitions for the CPU / system-RAM / OAM DMA bus slice.
package nes_bus_pkg;

    // DMA sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        RD    = 3'd3,
        WR    = 3'd4
    } dma_state_t;

    // CPU write to this address starts an OAM DMA.
    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

    // System RAM occupies every CPU address whose bits [15:13] match this.
    localparam logic [2:0] SYS_RAM_BASE_MASK = 3'b000;

    // Bytes copied per transfer; the index counter is 8 bits wide.
    localparam int OAM_BYTES = 256;

endpackage

// File: rtl/sys_ram_port_mux.sv
// Selects who drives the system RAM port: the CPU (passthrough with
// mirror aliasing) while the DMA is idle, otherwise the DMA read engine.
module sys_ram_port_mux
    import nes_bus_pkg::*;
(
    input  logic        i_cpu_sel,
    input  logic [2:0]  i_cpu_hi,
    input  logic [10:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    input  logic        i_cpu_wren,
    input  logic        i_cpu_rden,
    input  logic        i_dma_rden,
    input  logic [10:0] i_dma_addr,
    output logic [10:0] o_ram_addr,
    output logic [7:0]  o_ram_wdata,
    output logic        o_ram_wren,
    output logic        o_ram_rden
);

    logic w_ram_sel;

    assign w_ram_sel = (i_cpu_hi == SYS_RAM_BASE_MASK);

    // Port selection: CPU passthrough when selected, else DMA read or quiet.
    always_comb begin
        o_ram_addr  = 11'h000;
        o_ram_wdata = 8'h00;
        o_ram_wren  = 1'b0;
        o_ram_rden  = 1'b0;
        if (i_cpu_sel) begin
            o_ram_addr  = i_cpu_addr;
            o_ram_wdata = i_cpu_wdata;
            o_ram_wren  = i_cpu_wren & w_ram_sel;
            o_ram_rden  = i_cpu_rden & w_ram_sel;
        end else if (i_dma_rden) begin
            o_ram_addr = i_dma_addr;
            o_ram_rden = 1'b1;
        end
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller and system RAM port arbiter. A CPU write to the DMA
// register halts the CPU and copies one 256-byte page into OAM, one
// read/write pair every two clocks, aligned so reads start on even parity.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = nes_bus_pkg::DMA_REG_ADDR,
    parameter int          OAM_BYTES    = nes_bus_pkg::OAM_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_wren,
    input  logic        cpu_rden,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_wren,
    output logic        ram_rden,
    input  logic [7:0]  ram_rdata,
    output logic [15:0] ext_addr,
    output logic        ext_rden,
    input  logic [7:0]  ext_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_wren,
    output logic        dma_busy,
    output logic [2:0]  dbg_state,
    output logic [7:0]  dbg_page,
    output logic [7:0]  dbg_idx,
    output logic        dbg_par
);

    import nes_bus_pkg::dma_state_t, nes_bus_pkg::IDLE, nes_bus_pkg::HALT,
           nes_bus_pkg::ALIGN, nes_bus_pkg::RD, nes_bus_pkg::WR;

    localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

    dma_state_t r_state;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic       r_par;
    logic       r_src_ext;   // page decode captured in RD, steers WR data

    logic w_idle;
    logic w_rd;
    logic w_wr;
    logic w_trig;
    logic w_page_ext;
    logic w_dma_ram_rden;
    logic w_cpu_wren;

    assign w_idle         = (r_state == IDLE);
    assign w_rd           = (r_state == RD);
    assign w_wr           = (r_state == WR);
    assign w_trig         = w_idle & cpu_wren & (cpu_addr == DMA_REG_ADDR);
    assign w_page_ext     = (r_page[7:3] != 5'd0);
    assign w_dma_ram_rden = w_rd & ~w_page_ext;
    // The trigger write is consumed here and never reaches RAM.
    assign w_cpu_wren     = cpu_wren & ~w_trig;

    // Free-running parity used to align the first read to an even cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par <= 1'b0;
        end else begin
            r_par <= ~r_par;
        end
    end

    // DMA sequencer: trigger, halt/align, then 256 read/write pairs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_page    <= 8'h00;
            r_idx     <= 8'h00;
            r_src_ext <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        r_page  <= cpu_wdata;
                        r_idx   <= 8'h00;
                        r_state <= HALT;
                    end
                end
                HALT: begin
                    r_state <= r_par ? RD : ALIGN;
                end
                ALIGN: begin
                    r_state <= RD;
                end
                RD: begin
                    r_src_ext <= w_page_ext;
                    r_state   <= WR;
                end
                WR: begin
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= 8'h00;
                        r_state <= IDLE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= RD;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    sys_ram_port_mux u_ram_mux (
        .i_cpu_sel   (w_idle),
        .i_cpu_hi    (cpu_addr[15:13]),
        .i_cpu_addr  (cpu_addr[10:0]),
        .i_cpu_wdata (cpu_wdata),
        .i_cpu_wren  (w_cpu_wren),
        .i_cpu_rden  (cpu_rden),
        .i_dma_rden  (w_dma_ram_rden),
        .i_dma_addr  ({r_page[2:0], r_idx}),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .o_ram_wren  (ram_wren),
        .o_ram_rden  (ram_rden)
    );

    assign cpu_rdata = ram_rdata;
    assign cpu_rdy   = w_idle;
    assign dma_busy  = ~w_idle;

    assign ext_rden  = w_rd & w_page_ext;
    assign ext_addr  = ext_rden ? {r_page, r_idx} : 16'h0000;

    assign oam_wren  = w_wr;
    assign oam_addr  = w_wr ? r_idx : 8'h00;
    assign oam_wdata = w_wr ? (r_src_ext ? ext_rdata : ram_rdata) : 8'h00;

    assign dbg_state = r_state;
    assign dbg_page  = r_page;
    assign dbg_idx   = r_idx;
    assign dbg_par   = r_par;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: RAM / external-bus / OAM environment models and
// a behavioural reference for transfer length, alignment and OAM contents.
`timescale 1ns/1ps
module tb_oam_dma_ctrl;
    import nes_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wren;
    logic        cpu_rden;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_wren;
    logic        ram_rden;
    logic [7:0]  ram_rdata;
    logic [15:0] ext_addr;
    logic        ext_rden;
    logic [7:0]  ext_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_wren;
    logic        dma_busy;
    logic [2:0]  dbg_state;
    logic [7:0]  dbg_page;
    logic [7:0]  dbg_idx;
    logic        dbg_par;

    int checks = 0;
    int errors = 0;

    // Clock and cycle counter (cycles since reset release; its LSB is the parity)
    always #5 clk = ~clk;

    int unsigned cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    oam_dma_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wren(cpu_wren), .cpu_rden(cpu_rden),
        .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rden(ram_rden),
        .ram_rdata(ram_rdata),
        .ext_addr(ext_addr), .ext_rden(ext_rden), .ext_rdata(ext_rdata),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_wren(oam_wren),
        .dma_busy(dma_busy),
        .dbg_state(dbg_state), .dbg_page(dbg_page), .dbg_idx(dbg_idx), .dbg_par(dbg_par)
    );

    // Environment: 2 KB system RAM and external bus, both 1-cycle read latency
    logic [7:0] ram_mem [0:2047];
    logic [7:0] ram_rdata_q = 8'h00;
    logic [7:0] ext_rdata_q = 8'h00;
    logic [7:0] ext_seed = 8'h00;

    function automatic logic [7:0] ext_fn(input logic [15:0] a);
        return (a[7:0] * 8'd7) ^ a[15:8] ^ ext_seed;
    endfunction

    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
        if (ram_rden) ram_rdata_q <= ram_mem[ram_addr];
        if (ext_rden) ext_rdata_q <= ext_fn(ext_addr);
    end
    assign ram_rdata = ram_rdata_q;
    assign ext_rdata = ext_rdata_q;

    // Reference model of RAM contents as the CPU has written them
    logic [7:0] exp_mem [0:2047];

    // Observations gathered during one transfer
    logic [7:0] got_oam [0:255];
    int  obs_busy, obs_oam_cnt, obs_ram_rd, obs_ext_cnt, obs_addr_err, obs_order_err;
    int  obs_rdy_err, obs_wren_err, obs_page_err, obs_par_err, obs_first_rd_par;
    bit  obs_timeout, obs_rdy_after, obs_halt_par;

    task automatic cpu_idle();
        cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_wren = 1'b0; cpu_rden = 1'b0;
    endtask

    // Fill one RAM page via CPU writes; mode 0 uses i^5A, mode 1 random bytes
    task automatic preload_page(input logic [2:0] pg, input bit mode);
        logic [7:0] d;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            d = mode ? 8'($urandom) : (8'(i) ^ 8'h5A);
            cpu_addr = {5'b00000, pg, 8'(i)}; cpu_wdata = d; cpu_wren = 1'b1; cpu_rden = 1'b0;
            exp_mem[{pg, 8'(i)}] = d;
        end
        @(negedge clk);
        cpu_idle();
    endtask

    // Trigger a transfer with HALT on the requested parity and record what happens
    task automatic do_dma(input logic [7:0] page, input bit halt_par, input bit interfere);
        bit done;
        logic [7:0] n;
        @(negedge clk);
        if (cyc[0] == halt_par) @(negedge clk);
        cpu_addr = DMA_REG_ADDR; cpu_wdata = page; cpu_wren = 1'b1; cpu_rden = 1'b0;
        obs_busy = 0; obs_oam_cnt = 0; obs_ram_rd = 0; obs_ext_cnt = 0; obs_addr_err = 0;
        obs_order_err = 0; obs_rdy_err = 0; obs_wren_err = 0; obs_page_err = 0; obs_par_err = 0;
        obs_first_rd_par = -1; obs_rdy_after = 1'b0; obs_halt_par = 1'b0;
        for (int i = 0; i < 256; i++) got_oam[i] = 8'h00;
        done = 1'b0;
        for (int k = 0; k < 600 && !done; k++) begin
            @(negedge clk);
            if (interfere && k >= 100 && k < 106) begin
                cpu_addr = 16'h0010; cpu_wdata = 8'h77; cpu_wren = 1'b1; cpu_rden = 1'b1;
            end else if (interfere && k >= 106 && k < 112) begin
                cpu_addr = DMA_REG_ADDR; cpu_wdata = 8'h80; cpu_wren = 1'b1; cpu_rden = 1'b0;
            end else begin
                cpu_idle();
            end
            #1;
            if (k == 0) obs_halt_par = cyc[0];
            if (dma_busy !== 1'b1) begin
                done = 1'b1;
                obs_rdy_after = cpu_rdy;
            end else begin
                obs_busy++;
                n = 8'(obs_oam_cnt);
                if (cpu_rdy !== 1'b0) obs_rdy_err++;
                if (ram_wren !== 1'b0) obs_wren_err++;
                if (dbg_page !== page) obs_page_err++;
                if (dbg_par !== cyc[0]) obs_par_err++;
                if (ram_rden === 1'b1) begin
                    obs_ram_rd++;
                    if (ram_addr !== {page[2:0], n}) obs_addr_err++;
                end
                if (ext_rden === 1'b1) begin
                    if (ext_addr !== {page, 8'(obs_ext_cnt)}) obs_addr_err++;
                    obs_ext_cnt++;
                end
                if ((ram_rden === 1'b1 || ext_rden === 1'b1) && obs_first_rd_par < 0)
                    obs_first_rd_par = int'(cyc[0]);
                if (oam_wren === 1'b1) begin
                    if (oam_addr !== n) obs_order_err++;
                    got_oam[oam_addr] = oam_wdata;
                    obs_oam_cnt++;
                end
            end
        end
        obs_timeout = !done;
        cpu_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_idle();
        cpu_addr = 16'h0123; cpu_rden = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy got %b want 1", cpu_rdy); end
        checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", dma_busy); end
        checks++; if (oam_wren !== 1'b0 || ext_rden !== 1'b0 || ram_wren !== 1'b0) begin errors++;
            $display("FAIL rst_strobes got oam=%b ext=%b ramw=%b want 0", oam_wren, ext_rden, ram_wren); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got %0d want %0d", dbg_state, IDLE); end
        checks++; if (dbg_page !== 8'h00 || dbg_idx !== 8'h00 || dbg_par !== 1'b0) begin errors++;
            $display("FAIL rst_regs got page=%h idx=%h par=%b want 0", dbg_page, dbg_idx, dbg_par); end
        checks++; if (ram_addr !== 11'h123 || ram_rden !== 1'b1) begin errors++;
            $display("FAIL rst_passthru got addr=%h rden=%b want 123/1", ram_addr, ram_rden); end
        @(negedge clk);
        cpu_idle();
        reset = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [15:0] a, hi, ra;
        logic [7:0] d;
        @(negedge clk);
        cpu_addr = 16'h0805; cpu_wdata = 8'hA5; cpu_wren = 1'b1; cpu_rden = 1'b0;
        #1;
        exp_mem[11'h005] = 8'hA5;
        checks++; if (ram_addr !== 11'h005 || ram_wren !== 1'b1 || ram_wdata !== 8'hA5 || cpu_rdy !== 1'b1) begin errors++;
            $display("FAIL pt_mirror_wr got addr=%h wren=%b wdata=%h rdy=%b want 005/1/a5/1", ram_addr, ram_wren, ram_wdata, cpu_rdy); end
        @(negedge clk);
        cpu_addr = 16'h0005; cpu_wren = 1'b0; cpu_rden = 1'b1;
        #1;
        checks++; if (ram_addr !== 11'h005 || ram_rden !== 1'b1 || cpu_rdy !== 1'b1) begin errors++;
            $display("FAIL pt_rd_addr got addr=%h rden=%b rdy=%b want 005/1/1", ram_addr, ram_rden, cpu_rdy); end
        @(negedge clk);
        cpu_idle();
        #1;
        checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL pt_rdata got %h want a5", cpu_rdata); end
        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom_range(0, 16'h1FFF));
            d = 8'($urandom);
            @(negedge clk);
            cpu_addr = a; cpu_wdata = d; cpu_wren = 1'b1; cpu_rden = 1'b0;
            #1;
            exp_mem[a[10:0]] = d;
            checks++; if (ram_wren !== 1'b1 || ram_addr !== a[10:0]) begin errors++;
                $display("FAIL pt_rand_wr addr %h got wren=%b ram_addr=%h want 1/%h", a, ram_wren, ram_addr, a[10:0]); end
            hi = 16'($urandom_range(16'h2000, 16'hFFFF));
            if (hi == DMA_REG_ADDR) hi = hi + 16'd1;
            @(negedge clk);
            cpu_addr = hi; cpu_wdata = ~d; cpu_wren = 1'b1; cpu_rden = 1'b1;
            #1;
            checks++; if (ram_wren !== 1'b0 || ram_rden !== 1'b0 || dma_busy !== 1'b0) begin errors++;
                $display("FAIL pt_nonram addr %h got wren=%b rden=%b busy=%b want 0", hi, ram_wren, ram_rden, dma_busy); end
            ra = {3'b000, 2'($urandom_range(0, 3)), a[10:0]};
            @(negedge clk);
            cpu_addr = ra; cpu_wren = 1'b0; cpu_rden = 1'b1;
            @(negedge clk);
            cpu_idle();
            #1;
            checks++; if (cpu_rdata !== exp_mem[a[10:0]]) begin errors++;
                $display("FAIL pt_rand_rd addr %h got %h want %h", ra, cpu_rdata, exp_mem[a[10:0]]); end
        end
    endtask

    task automatic test_dma_even();
        int bad;
        preload_page(3'd2, 1'b0);
        do_dma(8'h02, 1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (got_oam[i] !== (8'(i) ^ 8'h5A)) bad++;
        checks++; if (obs_timeout) begin errors++; $display("FAIL even_timeout got busy>=600 want 513"); end
        checks++; if (obs_halt_par !== 1'b1) begin errors++; $display("FAIL even_halt_par got %b want 1", obs_halt_par); end
        checks++; if (obs_busy != 513) begin errors++; $display("FAIL even_busy got %0d want 513", obs_busy); end
        checks++; if (obs_first_rd_par != 0) begin errors++; $display("FAIL even_rd_par got %0d want 0", obs_first_rd_par); end
        checks++; if (obs_oam_cnt != 256 || obs_order_err != 0) begin errors++;
            $display("FAIL even_oam_seq got writes=%0d order_err=%0d want 256/0", obs_oam_cnt, obs_order_err); end
        checks++; if (bad != 0) begin errors++; $display("FAIL even_oam_data got %0d bad bytes want 0", bad); end
        checks++; if (obs_ram_rd != 256 || obs_ext_cnt != 0 || obs_addr_err != 0) begin errors++;
            $display("FAIL even_reads got ram=%0d ext=%0d addr_err=%0d want 256/0/0", obs_ram_rd, obs_ext_cnt, obs_addr_err); end
        checks++; if (obs_rdy_err != 0 || obs_rdy_after !== 1'b1) begin errors++;
            $display("FAIL even_rdy got busy_rdy_err=%0d rdy_after=%b want 0/1", obs_rdy_err, obs_rdy_after); end
        checks++; if (obs_par_err != 0) begin errors++; $display("FAIL even_par_track got %0d want 0", obs_par_err); end
    endtask

    task automatic test_dma_odd();
        int bad;
        logic [2:0] pg;
        pg = 3'($urandom_range(0, 7));
        preload_page(pg, 1'b1);
        do_dma({5'b00000, pg}, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (got_oam[i] !== exp_mem[{pg, 8'(i)}]) bad++;
        checks++; if (obs_halt_par !== 1'b0 || obs_timeout) begin errors++;
            $display("FAIL odd_setup got halt_par=%b timeout=%b want 0/0", obs_halt_par, obs_timeout); end
        checks++; if (obs_busy != 514) begin errors++; $display("FAIL odd_busy got %0d want 514", obs_busy); end
        checks++; if (obs_first_rd_par != 0) begin errors++; $display("FAIL odd_rd_par got %0d want 0", obs_first_rd_par); end
        checks++; if (bad != 0 || obs_oam_cnt != 256) begin errors++;
            $display("FAIL odd_oam page %0d got %0d bad of %0d writes want 0 of 256", pg, bad, obs_oam_cnt); end
    endtask

    task automatic test_dma_ext();
        logic [7:0] pages [0:1];
        logic [7:0] pg;
        int bad;
        bit hp;
        pages[0] = 8'h80;
        pages[1] = 8'($urandom_range(8'h08, 8'hFF));
        for (int t = 0; t < 2; t++) begin
            pg = pages[t];
            ext_seed = 8'($urandom);
            hp = 1'($urandom_range(0, 1));
            do_dma(pg, hp, 1'b0);
            bad = 0;
            for (int i = 0; i < 256; i++) if (got_oam[i] !== ext_fn({pg, 8'(i)})) bad++;
            checks++; if (obs_busy != (hp ? 513 : 514)) begin errors++;
                $display("FAIL ext_busy page %h got %0d want %0d", pg, obs_busy, hp ? 513 : 514); end
            checks++; if (obs_ext_cnt != 256 || obs_ram_rd != 0 || obs_addr_err != 0) begin errors++;
                $display("FAIL ext_reads page %h got ext=%0d ram=%0d addr_err=%0d want 256/0/0", pg, obs_ext_cnt, obs_ram_rd, obs_addr_err); end
            checks++; if (bad != 0 || obs_oam_cnt != 256) begin errors++;
                $display("FAIL ext_oam page %h got %0d bad of %0d writes want 0 of 256", pg, bad, obs_oam_cnt); end
        end
    endtask

    task automatic test_cpu_blocked();
        int bad;
        bit hp;
        @(negedge clk);
        cpu_addr = 16'h0010; cpu_wdata = 8'h3C; cpu_wren = 1'b1; cpu_rden = 1'b0;
        exp_mem[11'h010] = 8'h3C;
        @(negedge clk);
        cpu_idle();
        hp = 1'($urandom_range(0, 1));
        do_dma(8'h02, hp, 1'b1);
        bad = 0;
        for (int i = 0; i < 256; i++) if (got_oam[i] !== exp_mem[{3'd2, 8'(i)}]) bad++;
        checks++; if (obs_wren_err != 0) begin errors++; $display("FAIL blk_ram_wren got %0d cycles want 0", obs_wren_err); end
        checks++; if (obs_page_err != 0 || obs_ext_cnt != 0) begin errors++;
            $display("FAIL blk_retrigger got page_err=%0d ext_reads=%0d want 0/0", obs_page_err, obs_ext_cnt); end
        checks++; if (obs_busy != (hp ? 513 : 514) || bad != 0) begin errors++;
            $display("FAIL blk_transfer got busy=%0d bad=%0d want %0d/0", obs_busy, bad, hp ? 513 : 514); end
        @(negedge clk);
        cpu_addr = 16'h0010; cpu_rden = 1'b1;
        @(negedge clk);
        cpu_idle();
        #1;
        checks++; if (cpu_rdata !== 8'h3C) begin errors++; $display("FAIL blk_ram_kept got %h want 3c", cpu_rdata); end
    endtask

    task automatic test_reset_mid();
        bit found;
        int bad;
        @(negedge clk);
        cpu_addr = DMA_REG_ADDR; cpu_wdata = 8'h02; cpu_wren = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk);
            cpu_idle();
            #1;
            if (dbg_idx === 8'h40) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_reach got no idx 40 want idx 40"); end
        reset = 1'b1;
        #1;
        checks++; if (dbg_state !== IDLE || cpu_rdy !== 1'b1 || dma_busy !== 1'b0) begin errors++;
            $display("FAIL mid_rst_state got state=%0d rdy=%b busy=%b want %0d/1/0", dbg_state, cpu_rdy, dma_busy, IDLE); end
        checks++; if (oam_wren !== 1'b0 || dbg_idx !== 8'h00 || dbg_page !== 8'h00) begin errors++;
            $display("FAIL mid_rst_regs got oam_wren=%b idx=%h page=%h want 0/00/00", oam_wren, dbg_idx, dbg_page); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_dma(8'h02, 1'($urandom_range(0, 1)), 1'b0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (got_oam[i] !== exp_mem[{3'd2, 8'(i)}]) bad++;
        checks++; if (obs_oam_cnt != 256 || obs_order_err != 0 || bad != 0 || obs_timeout) begin errors++;
            $display("FAIL mid_restart got writes=%0d order_err=%0d bad=%0d want 256/0/0", obs_oam_cnt, obs_order_err, bad); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cpu_idle();
        reset = 1'b1;
        test_reset();
        test_passthrough();
        test_dma_even();
        test_dma_odd();
        test_dma_ext();
        test_cpu_blocked();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Controller and arbiter for the 2 KB system RAM port and the sprite OAM write port. Normally passes CPU accesses in `$0000-$1FFF` straight through to system RAM. A CPU write to `$4014` starts OAM DMA: the CPU is halted and 256 bytes are copied from page `$XX00-$XXFF` into OAM, one read/write pair per two cycles. Sits between the 6502 core bus, `SYS_RAM`, the external bus (non-RAM pages) and the PPU OAM.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014, CPU address that triggers DMA.
- `OAM_BYTES`, 256, bytes per transfer. Fixed; the index counter is 8 bits.

Ports:
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: asynchronous, active-high.
- `cpu_addr` in 16: CPU bus address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_wren` in 1: CPU write strobe.
- `cpu_rden` in 1: CPU read strobe.
- `cpu_rdata` out 8: equals `ram_rdata`. Pure passthrough.
- `cpu_rdy` out 1: 0 halts the CPU.
- `ram_addr` out 11: system RAM address.
- `ram_wdata` out 8: system RAM write data.
- `ram_wren` out 1: system RAM write enable.
- `ram_rden` out 1: system RAM read enable.
- `ram_rdata` in 8: system RAM read data, 1-cycle latency.
- `ext_addr` out 16: external-bus address for DMA source pages ≥ `$08`.
- `ext_rden` out 1: external-bus read strobe.
- `ext_rdata` in 8: external-bus read data, 1-cycle latency.
- `oam_addr` out 8: OAM write address.
- `oam_wdata` out 8: OAM write data.
- `oam_wren` out 1: OAM write strobe.
- `dma_busy` out 1: high while the state is not IDLE.

## Operation
- States:
  - IDLE
  - HALT: dummy cycle.
  - ALIGN: odd-cycle pad.
  - RD
  - WR
- Registers:
  - `page` (8 bits)
  - `idx` (8 bits)
  - `par`: free-running parity; toggles every clock, reset value 0.
- IDLE, RAM passthrough:
  - `ram_sel = (cpu_addr[15:13]==0)`.
  - `ram_addr = cpu_addr[10:0]`, so the `$0800-$1FFF` mirrors alias.
  - `ram_wren = cpu_wren & ram_sel`, `ram_rden = cpu_rden & ram_sel`, `ram_wdata = cpu_wdata`.
- IDLE, trigger:
  - `cpu_wren && cpu_addr==DMA_REG_ADDR` latches `page <= cpu_wdata` and `idx <= 0`, then goes to HALT.
  - The trigger write itself never reaches RAM.
- HALT:
  - `cpu_rdy=0`; all RAM, ext and OAM strobes are 0.
  - Next state is RD if `par==1`, else ALIGN. RD therefore always begins on a `par==0` cycle.
- ALIGN: same outputs as HALT; next state RD.
- RD:
  - If `page[7:3]==0`: `ram_rden=1`, `ram_addr={page[2:0],idx}`.
  - Otherwise: `ext_rden=1`, `ext_addr={page,idx}`.
  - Next state WR.
- WR:
  - `oam_wren=1`, `oam_addr=idx`.
  - `oam_wdata` is `ram_rdata` or `ext_rdata`, selected by the page decode registered in RD.
  - If `idx==8'hFF`, next state is IDLE; otherwise `idx<=idx+1` and next state is RD.
- CPU strobes are ignored in every non-IDLE state: no RAM access, no retrigger.
- `cpu_rdy` is combinational: `cpu_rdy = (state==IDLE)`.
- `idx` wraps 8'hFF→8'h00 only at the end of a transfer.
- Reset at any point:
  - State goes to IDLE; `page`, `idx` and `par` go to 0.
  - `cpu_rdy=1`.
  - Every other output is 0, except the combinational passthroughs, which follow the CPU inputs.
  - The partial transfer is abandoned and there is no resume.

## Timing
- Trigger sampled at edge T. HALT occupies cycle T+1, during which `cpu_rdy=0`.
- Busy length is 513 cycles with no ALIGN, 514 with ALIGN.
- The first OAM write is 2 or 3 cycles after HALT.
- The last WR cycle is followed by IDLE; `cpu_rdy=1` in that cycle.
- RAM read latency is exactly 1 cycle: data requested in RD is consumed in WR.
- The OAM write commits at the end of the WR cycle.
- CPU RAM reads in IDLE: data appears on `cpu_rdata` one cycle after `cpu_rden`, with no added latency.

## Structure
- Shared package `nes_bus_pkg` holds:
  - `dma_state_t` enum: IDLE, HALT, ALIGN, RD, WR.
  - `DMA_REG_ADDR`.
  - `SYS_RAM_BASE_MASK`, 3'b000 on `[15:13]`.
  - `OAM_BYTES`.
- One natural sub-module, `sys_ram_port_mux`: combinational selection between the CPU and DMA address, data and strobe sets for the RAM port. The FSM stays in `oam_dma_ctrl`.

## Test plan
- Passthrough: CPU write `$0805←8'hA5`, then read `$0005` → `ram_addr=11'h005` on both accesses; `cpu_rdata=8'hA5` one cycle after the read; `cpu_rdy` stays 1.
- RAM-page DMA, even start: preload `$0200-$02FF` with `i^8'h5A`; write `$4014←8'h02` with HALT on `par==1` → no ALIGN, `dma_busy` high for 513 cycles, OAM[i]=`i^8'h5A` for all 256 bytes.
- Odd start: same transfer with HALT on `par==0` → one ALIGN cycle, 514 busy cycles, first RD on a `par==0` cycle.
- External page: write `$4014←8'h80` → `ext_rden` pulses with `ext_addr` running 8000..80FF; `ram_rden` never asserts; OAM receives the `ext_rdata` values.
- CPU blocked during DMA: assert `cpu_wren` to `$0010` and to `$4014` mid-transfer → no `ram_wren`, no restart, `page` unchanged.
- Reset mid-transfer at `idx=8'h40` → next cycle: IDLE, `cpu_rdy=1`, `oam_wren=0`, `idx=0`; a new `$4014` write starts a clean transfer from idx 0.
